// File: rtl/timer_ctrl_if.sv
// -----------------------------------------------------------------------------
// timer_ctrl_if
// Purpose : groups the command and status signals of timer_ctrl into a single
//           bundle. The controlling agent (CPU glue, board logic, testbench)
//           uses the master modport; the timer itself uses the slave modport.
// Signals :
//   start    master->slave  single-cycle launch / resume command
//   pause    master->slave  single-cycle freeze command
//   clear    master->slave  single-cycle abort command
//   terminal master->slave  WIDTH-bit end-of-run count (0 = full 2^WIDTH span)
//   count    slave->master  current count (registered)
//   tick     slave->master  one-cycle pulse on every count advance
//   done     slave->master  one-cycle pulse when a run reaches terminal
//   busy     slave->master  high while running or paused
//   state    slave->master  IDLE=00, RUN=01, PAUSE=10, DONE=11
// -----------------------------------------------------------------------------
interface timer_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             pause;
  logic             clear;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             done;
  logic             busy;
  logic [1:0]       state;

  modport master (
    output start, pause, clear, terminal,
    input  count, tick, done, busy, state
  );

  modport slave (
    input  start, pause, clear, terminal,
    output count, tick, done, busy, state
  );
endinterface : timer_ctrl_if

// File: rtl/timer_ctrl.sv
// -----------------------------------------------------------------------------
// timer_ctrl
// Purpose : prescaled up-counter timer with start / pause / clear commands.
//           A prescaler divides clk by DIV; each prescaler wrap advances the
//           count by one and pulses tick. When the advanced count equals
//           terminal the run ends and done pulses.
// Parameters:
//   DIV    clk cycles per count tick (DIV >= 2)
//   WIDTH  width of count and terminal
// Ports   :
//   clk    system clock, all logic on its rising edge
//   rst    synchronous active-high reset
//   bus    timer_ctrl_if.slave (start/pause/clear/terminal in,
//          count/tick/done/busy/state out)
// Configuration macro:
//   TIMER_CTRL_AUTORELOAD_EN  defined   -> at the done edge count returns to 0
//                                          and the timer keeps running
//                             undefined -> at the done edge count holds
//                                          terminal and the timer enters DONE
// -----------------------------------------------------------------------------
module timer_ctrl #(
  parameter int unsigned DIV   = 12000000,
  parameter int unsigned WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  timer_ctrl_if.slave bus
);

  localparam int unsigned    PSC_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [PSC_W-1:0] psc_q,   psc_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q,  tick_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] count_inc_s;

  // Wrapping increment; the same value is both the next count and the value
  // compared against terminal, so terminal=0 naturally means a full span.
  assign count_inc_s = count_q + {{(WIDTH-1){1'b0}}, 1'b1};

  // Next-state and next-output logic; clear outranks start, start outranks pause.
  always_comb begin
    state_d = state_q;
    psc_d   = psc_q;
    count_d = count_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;

    if (bus.clear) begin
      state_d = ST_IDLE;
      psc_d   = {PSC_W{1'b0}};
      count_d = {WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d = ST_RUN;
            psc_d   = {PSC_W{1'b0}};
            count_d = {WIDTH{1'b0}};
          end else begin
            state_d = state_q;
          end
        end

        ST_PAUSE: begin
          // Resume keeps psc, so the interrupted tick period is completed.
          if (bus.start) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_PAUSE;
          end
        end

        ST_RUN: begin
          // start is meaningless while running, so pause is evaluated directly.
          if (bus.pause) begin
            state_d = ST_PAUSE;
          end else if (psc_q == PSC_LAST) begin
            psc_d   = {PSC_W{1'b0}};
            count_d = count_inc_s;
            tick_d  = 1'b1;
            if (count_inc_s == bus.terminal) begin
              done_d = 1'b1;
`ifdef TIMER_CTRL_AUTORELOAD_EN
              count_d = {WIDTH{1'b0}};
              state_d = ST_RUN;
`else
              count_d = count_inc_s;
              state_d = ST_DONE;
`endif
            end else begin
              done_d  = 1'b0;
              state_d = ST_RUN;
            end
          end else begin
            psc_d = psc_q + {{(PSC_W-1){1'b0}}, 1'b1};
          end
        end

        default: begin
          state_d = ST_IDLE;
          psc_d   = {PSC_W{1'b0}};
          count_d = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State, prescaler, count and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      psc_q   <= {PSC_W{1'b0}};
      count_q <= {WIDTH{1'b0}};
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      psc_q   <= psc_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;
  assign bus.busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);

endmodule : timer_ctrl

// File: tb/tb_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_ctrl
// Purpose : self-checking bench for timer_ctrl (DIV=4, WIDTH=4). Directed
//           scenarios followed by random command traffic; every cycle the DUT
//           outputs are compared with a cycle-level behavioural model that
//           counts elapsed run cycles per tick period with plain integers.
// -----------------------------------------------------------------------------
module tb_timer_ctrl;
  localparam int DIV   = 4;
  localparam int WIDTH = 4;
  localparam int SPAN  = 16;

  logic clk = 1'b0;
  logic rst;

  timer_ctrl_if #(.WIDTH(WIDTH)) bus ();

  timer_ctrl #(.DIV(DIV), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: 0=IDLE 1=RUN 2=PAUSE 3=DONE
  int m_state = 0;
  int m_cnt   = 0;
  int m_phase = 0;   // run cycles elapsed in the current tick period
  int m_tick  = 0;
  int m_done  = 0;
  int tick_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input bit s, input bit p, input bit c, input bit r, input int term);
    m_tick = 0;
    m_done = 0;
    if (r || c) begin
      m_state = 0; m_cnt = 0; m_phase = 0;
    end else if (s && (m_state == 0 || m_state == 3)) begin
      m_state = 1; m_cnt = 0; m_phase = 0;
    end else if (s && m_state == 2) begin
      m_state = 1;
    end else if (p && m_state == 1) begin
      m_state = 2;
    end else if (m_state == 1) begin
      m_phase = m_phase + 1;
      if (m_phase == DIV) begin
        m_phase = 0;
        m_cnt   = (m_cnt + 1) % SPAN;
        m_tick  = 1;
        if (m_cnt == term) begin
          m_done = 1;
`ifdef TIMER_CTRL_AUTORELOAD_EN
          m_cnt = 0;
`else
          m_state = 3;
`endif
        end
      end
    end
  endtask

  // One clock: apply inputs, clock the DUT and the model, compare 1 ns later.
  task automatic step(input bit s, input bit p, input bit c, input bit r, input int term);
    logic [3:0] t4;
    t4 = term[3:0];
    bus.start    = s;
    bus.pause    = p;
    bus.clear    = c;
    bus.terminal = t4;
    rst          = r;
    @(posedge clk);
    model_edge(s, p, c, r, term);
    #1;
    chk("count", {28'd0, bus.count}, m_cnt);
    chk("tick",  {31'd0, bus.tick},  m_tick);
    chk("done",  {31'd0, bus.done},  m_done);
    chk("busy",  {31'd0, bus.busy},  (m_state == 1 || m_state == 2) ? 1 : 0);
    chk("state", {30'd0, bus.state}, m_state);
    if (bus.tick === 1'b1) tick_seen++;
  endtask

  task automatic idle(input int n, input int term);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, term);
  endtask

  initial begin
    int term_r;
    bit rs, rc, rp, rr;

    bus.start = 1'b0; bus.pause = 1'b0; bus.clear = 1'b0; bus.terminal = 4'd0;
    rst = 1'b1;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0);
    chk("reset_state", {30'd0, bus.state}, 0);
    idle(3, 0);

    // terminal=3 run, then long hold
    tick_seen = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 3);
    idle(12, 3);
`ifndef TIMER_CTRL_AUTORELOAD_EN
    chk("r031_ticks", tick_seen, 3);
    chk("r031_state", {30'd0, bus.state}, 3);
    idle(22, 3);
    chk("r031_hold_count", {28'd0, bus.count}, 3);
`else
    idle(22, 3);
`endif

    // Pause one cycle after the second tick, hold, resume
    step(1'b1, 1'b0, 1'b0, 1'b0, 5);
    idle(8, 5);
    step(1'b0, 1'b1, 1'b0, 1'b0, 5);
    idle(10, 5);
    chk("r032_paused_count", {28'd0, bus.count}, 2);
    chk("r032_paused_busy", {31'd0, bus.busy}, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5);
    idle(3, 5);
    chk("r032_no_tick_yet", {28'd0, bus.count}, 2);
    idle(1, 5);
    chk("r032_third_tick", {31'd0, bus.tick}, 1);
    idle(6, 5);

    // clear + start together while running
    step(1'b1, 1'b0, 1'b1, 1'b0, 9);
    chk("r033_state", {30'd0, bus.state}, 0);
    tick_seen = 0;
    idle(10, 9);
    chk("r033_no_tick", tick_seen, 0);

    // terminal=0 full span (wraps or stops depending on build)
    tick_seen = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(SPAN * DIV, 0);
    chk("r035_ticks", tick_seen, SPAN);
    chk("r035_count", {28'd0, bus.count}, 0);
    idle(SPAN * DIV + 6, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle(DIV + 2, 0);

    // rst while count=5 in RUN
    step(1'b0, 1'b0, 1'b1, 1'b0, 10);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10);
    idle(5 * DIV, 10);
    chk("r036_pre_count", {28'd0, bus.count}, 5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 10);
    chk("r036_rst_count", {28'd0, bus.count}, 0);
    chk("r036_rst_busy", {31'd0, bus.busy}, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 10);
    idle(DIV, 10);
    chk("r036_first_tick_count", {28'd0, bus.count}, 1);
    idle(3, 10);

    // Random command traffic against the model
    term_r = 7;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) term_r = $urandom_range(0, SPAN - 1);
      rs = ($urandom_range(0, 9) == 0);
      rp = ($urandom_range(0, 14) == 0);
      rc = ($urandom_range(0, 59) == 0);
      rr = ($urandom_range(0, 249) == 0);
      step(rs, rp, rc, rr, term_r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule : tb_timer_ctrl

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter DIV, default 12000000, clk cycles per count tick; legal range DIV >= 2.
REQ-002 Parameter WIDTH, default 4, width of count and terminal.
REQ-003 clk  input  1  system clock (12 MHz on board); all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle command: launch from IDLE/DONE, resume from PAUSE.
REQ-006 pause  input  1  single-cycle command: freeze a running timer.
REQ-007 clear  input  1  single-cycle command: abort to IDLE.
REQ-008 terminal  input  WIDTH  count value that ends a run; 0 means full 2^WIDTH span.
REQ-009 count  output  WIDTH  current count, registered (drives led).
REQ-010 tick  output  1  one-cycle pulse on every count advance.
REQ-011 done  output  1  one-cycle pulse when a run reaches terminal.
REQ-012 busy  output  1  high in RUN or PAUSE.
REQ-013 state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Function
REQ-014 Internal prescaler psc, width clog2(DIV), counts 0..DIV-1, advances only in RUN.
REQ-015 Tick edge: edge where state=RUN, psc=DIV-1, and no pause/clear is accepted; psc<=0, count<=count+1 mod 2^WIDTH, tick<=1 (tick is high in the same cycle that count shows the new value).
REQ-016 Done condition: at a tick edge, (count+1) mod 2^WIDTH equals terminal; terminal is sampled live at each tick edge.
REQ-017 Command priority: clear > start > pause; at most one command is acted on per edge.
REQ-018 clear, any state: state<=IDLE, count<=0, psc<=0, tick<=0, done<=0.
REQ-019 start in IDLE or DONE: state<=RUN, count<=0, psc<=0; first tick occurs DIV cycles after the accepting edge.
REQ-020 start in PAUSE: state<=RUN, count and psc unchanged (phase preserved).
REQ-021 start in RUN: ignored; a pause in the same cycle is acted on.
REQ-022 pause in RUN: state<=PAUSE, psc and count held, tick suppressed even if psc=DIV-1; pause in other states: ignored.
REQ-023 In PAUSE, DONE, and IDLE: psc and count hold, tick=0.
REQ-024 tick and done are deasserted on every edge that does not set them.
REQ-025 busy and state are combinational decodes of the state register.

Reset
REQ-026 rst dominates all commands: state=IDLE, count=0, psc=0, tick=0, done=0, busy=0.
REQ-027 rst asserted mid-run discards progress; the first start after rst deasserts behaves per REQ-019.

Configuration
REQ-028 Macro TIMER_CTRL_AUTORELOAD_EN selects the end-of-run behaviour.
REQ-029 Defined: at the done edge, count<=0, done<=1, tick<=1, and state stays RUN; psc continues, so runs repeat without a gap.
REQ-030 Undefined: at the done edge, count<=terminal (0 when terminal=0), done<=1, tick<=1, and state<=DONE, holding until start or clear.

Verification (DIV=4, WIDTH=4 unless stated)
REQ-031 Macro undefined, terminal=3, start at edge E: ticks at E+4, E+8, and E+12; count 1, 2, 3; done coincides with the third tick; state=DONE; count holds 3 for 20+ cycles.
REQ-032 Pause one cycle after the second tick, hold 10 cycles, then start: the third tick arrives exactly 4 RUN cycles after the second tick; count is unchanged during PAUSE and busy=1 throughout.
REQ-033 In RUN, assert clear and start in the same cycle: next cycle state=IDLE, count=0, and no tick follows.
REQ-034 Macro defined, terminal=0: count steps 1..15, then 0 with tick and done high together; state stays RUN and the cycle repeats with 4-cycle tick spacing.
REQ-035 Macro undefined, terminal=0: 16 ticks, then DONE with count=0; a following start restarts from 0.
REQ-036 rst pulsed while count=5 in RUN: all outputs reach their reset values next cycle; a subsequent start gives the first tick 4 cycles later with count=1.
